writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Shares the single register-file writeback port between several result producers (ALU, load unit, multiply/divide unit) using round-robin arbitration with a valid/ready handshake. It drives the register file's `writeback_address` / `writeback_data` / `writeback_enable` from a registered output stage. An optional scoreboard tracks destination registers with writes still outstanding and flags `rs` / `rt` hazards to the issue stage.

## Interface
- `NUM_REQ`, default 3: number of requesters; index 0 = ALU, 1 = load, 2 = mul/div.
- `DATA_WIDTH`, default 32: writeback data width.
- `ADDR_WIDTH`, default 5: register address width.
- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  pipeline advance; when low no grant is issued.
- `req_valid`  in  NUM_REQ  requester i has a result.
- `req_address`  in  NUM_REQ*ADDR_WIDTH  destination of requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data`  in  NUM_REQ*DATA_WIDTH  result of requester i, sliced the same way.
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant; combinational from `req_valid`, `enable` and the pointer.
- `writeback_address`  out  ADDR_WIDTH  registered.
- `writeback_data`  out  DATA_WIDTH  registered.
- `writeback_enable`  out  1  registered.
- Scoreboard only:
  - `issue_valid`  in  1  an instruction with a destination register issues this cycle.
  - `issue_address`  in  ADDR_WIDTH  its destination register.
  - `rs`, `rt`  in  ADDR_WIDTH  source registers being decoded.
  - `rs_busy`, `rt_busy`  out  1  combinational; source has a pending write.

## Operation
- Round-robin pointer `ptr` (0..NUM_REQ-1). The grant goes to the first i with `req_valid[i]`, scanning from `ptr` upward with wrap-around.
- Handshake:
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - At most one transfer per cycle.
  - A requester holds `valid`, `address` and `data` stable until it is granted.
- After a transfer from index g, `ptr` becomes (g+1) mod NUM_REQ. With no transfer, `ptr` holds.
- `enable` low: `req_ready` = 0, `ptr` holds, and `writeback_enable` is 0 on the next cycle.
- Address 0 transfers:
  - Granted and consumed normally.
  - Next-cycle `writeback_enable` = 0, so no write to $R0 reaches the register file.
  - Still advances `ptr`.
- No transfer in a cycle: next-cycle `writeback_enable` = 0. `writeback_address` and `writeback_data` hold their last values.
- Scoreboard:
  - One pending bit per register.
  - `issue_valid` with `issue_address` != 0 sets the bit.
  - A transfer whose address matches clears the bit.
  - If set and clear hit the same register in the same cycle, set wins; the newer producer stays pending.
  - Bit 0 is never set.
  - `rs_busy` = pending[`rs`] && `rs` != 0; `rt_busy` likewise.
  - The writeback currently in the output register counts as not busy, because the register file forwards it internally.

## Timing
- Reset values: `writeback_address` = 0, `writeback_data` = 0, `writeback_enable` = 0, `ptr` = 0, all pending bits = 0.
- `req_ready` is 0 while `reset` is high.
- Latency: a transfer in cycle N appears on the writeback outputs in cycle N+1, and the register file commits it at the end of N+1.
- Throughput: one writeback per cycle.
- Worst-case wait for a continuously valid requester is NUM_REQ-1 transfers.
- Reset mid-operation: an in-flight output write is dropped (`writeback_enable` is forced to 0), pending bits clear, and requesters re-present after reset.
- `rs_busy` / `rt_busy` reflect pending state as of the current cycle's registered bits. A clear from a same-cycle transfer is not visible until N+1.

## Configuration
- Macro `WRITEBACK_ARBITER_SCOREBOARD_EN`.
- Defined: scoreboard ports and logic are present as described.
- Undefined:
  - The ports `issue_valid`, `issue_address`, `rs`, `rt`, `rs_busy` and `rt_busy` are not present.
  - No pending-state storage is built.
  - Arbitration behaviour is identical.

## Test plan
- Reset, then only req 1 valid with address 7, data 0xDEADBEEF:
  - `req_ready` = 3'b010 in the same cycle.
  - Next cycle `writeback_enable` = 1, `writeback_address` = 7, `writeback_data` = 0xDEADBEEF.
  - Then `writeback_enable` = 0.
- All three requesters valid and held for 6 cycles from reset:
  - Grant order 0, 1, 2, 0, 1, 2.
  - Exactly one `req_ready` bit high each cycle.
- Req 2 valid with address 0, data 0x1234:
  - Granted; next cycle `writeback_enable` = 0.
  - `ptr` advances, so a following all-valid cycle grants 0.
- `enable` low for 3 cycles with req 0 valid:
  - `req_ready` = 0 throughout and `writeback_enable` = 0.
  - On `enable` rising, req 0 is granted immediately.
- Scoreboard, with issue of address 9 in cycle N:
  - `rs` = 9 gives `rs_busy` = 1 from N+1.
  - A transfer to 9 in cycle M gives `rs_busy` = 0 from M+1.
  - Issue and transfer of 9 in the same cycle leaves `rs_busy` = 1.
- Assert `reset` while a write to address 5 is in the output register and register 5 is pending:
  - `writeback_enable` drops to 0 immediately.
  - `rt_busy` for `rt` = 5 reads 0 after reset.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
//   Requester-side bundle for the writeback arbiter. Each requester i owns
//   one bit of req_valid/req_ready and one slice of req_address/req_data
//   at [i*WIDTH +: WIDTH].
//   master : result producers (drive valid/address/data, receive ready)
//   slave  : the arbiter (receives valid/address/data, drives ready)
interface writeback_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_address;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;

   modport master (
      output req_valid,
      output req_address,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_address,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Shares the single register-file writeback port between NUM_REQ result
//   producers (0 = ALU, 1 = load, 2 = mul/div) with round-robin arbitration
//   and a valid/ready handshake. The granted result is registered onto the
//   writeback outputs one cycle after the transfer. Writes to register 0 are
//   consumed but never enabled towards the register file.
//
//   Optional scoreboard, built when WRITEBACK_ARBITER_SCOREBOARD_EN is
//   defined: one pending bit per register, set at issue and cleared when the
//   matching writeback transfers; rs_busy/rt_busy report pending sources.
//
// Ports
//   clock, reset        clock; asynchronous active-high reset
//   enable              pipeline advance; no grant while low
//   req_bus (slave)     req_valid/req_address/req_data in, req_ready out
//   writeback_address   registered destination register
//   writeback_data      registered result
//   writeback_enable    registered write strobe
//   issue_valid, issue_address, rs, rt, rs_busy, rt_busy
//                       scoreboard ports (only with the macro defined)
module writeback_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   writeback_arbiter_if.slave    req_bus,
   output logic [ADDR_WIDTH-1:0] writeback_address,
   output logic [DATA_WIDTH-1:0] writeback_data,
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
   output logic                  writeback_enable,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_address,
   input  logic [ADDR_WIDTH-1:0] rs,
   input  logic [ADDR_WIDTH-1:0] rt,
   output logic                  rs_busy,
   output logic                  rt_busy
`else
   output logic                  writeback_enable
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      ptr_nxt;
   logic [PTR_W:0]        scan_idx;
   logic                  found;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    ready;
   logic                  xfer;
   logic [ADDR_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0] sel_data;

   // Scan from ptr upward with wrap-around; the first valid requester wins.
   // scan_idx carries one extra bit so ptr + k can exceed NUM_REQ-1 before
   // the wrap is folded back.
   always_comb begin
      grant    = '0;
      ptr_nxt  = ptr;
      found    = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, ptr} + (PTR_W+1)'(k);
         if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
         end
         if (!found && req_bus.req_valid[scan_idx[PTR_W-1:0]]) begin
            found                          = 1'b1;
            grant[scan_idx[PTR_W-1:0]]     = 1'b1;
            if (scan_idx == (PTR_W+1)'(NUM_REQ - 1)) begin
               ptr_nxt = '0;
            end else begin
               ptr_nxt = scan_idx[PTR_W-1:0] + PTR_W'(1);
            end
         end
      end
   end

   // Ready is suppressed during reset too, so nothing is consumed while the
   // output stage is being cleared.
   always_comb begin
      ready = '0;
      if (enable && !reset) begin
         ready = grant;
      end
   end

   assign req_bus.req_ready = ready;
   assign xfer              = |ready;

   always_comb begin
      sel_address = '0;
      sel_data    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_address = req_bus.req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data    = req_bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Address/data only move on a transfer; idle cycles keep the last values
   // and just drop the strobe. A transfer to register 0 still advances ptr.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr               <= '0;
         writeback_address <= '0;
         writeback_data    <= '0;
         writeback_enable  <= 1'b0;
      end else begin
         writeback_enable <= xfer && (sel_address != '0);
         if (xfer) begin
            ptr               <= ptr_nxt;
            writeback_address <= sel_address;
            writeback_data    <= sel_data;
         end
      end
   end

`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_nxt;

   // Clear is applied before set so a same-cycle issue to the register being
   // written back leaves the newer producer pending.
   always_comb begin
      pending_nxt = pending;
      if (xfer) begin
         pending_nxt[sel_address] = 1'b0;
      end
      if (issue_valid && (issue_address != '0)) begin
         pending_nxt[issue_address] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   // The clear happens at transfer time, so the write sitting in the output
   // register already reads as not busy; the register file forwards it.
   assign rs_busy = pending[rs] && (rs != '0);
   assign rt_busy = pending[rt] && (rt != '0);
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
   localparam int NR = 3;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [AW-1:0] writeback_address;
   logic [DW-1:0] writeback_data;
   logic          writeback_enable;
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
   logic          issue_valid;
   logic [AW-1:0] issue_address;
   logic [AW-1:0] rs;
   logic [AW-1:0] rt;
   logic          rs_busy;
   logic          rt_busy;
`endif

   always #5 clock = ~clock;

   writeback_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   writeback_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock             (clock),
      .reset             (reset),
      .enable            (enable),
      .req_bus           (bus.slave),
      .writeback_address (writeback_address),
      .writeback_data    (writeback_data),
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      .writeback_enable  (writeback_enable),
      .issue_valid       (issue_valid),
      .issue_address     (issue_address),
      .rs                (rs),
      .rt                (rt),
      .rs_busy           (rs_busy),
      .rt_busy           (rt_busy)
`else
      .writeback_enable  (writeback_enable)
`endif
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wb_t;

   wb_t exp_q[$];
   wb_t e;
   int  tests_run    = 0;
   int  tests_failed = 0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_reqs();
      bus.req_valid   = '0;
      bus.req_address = '0;
      bus.req_data    = '0;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_valid[i]             = 1'b1;
      bus.req_address[i*AW +: AW]  = a;
      bus.req_data[i*DW +: DW]     = d;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wb_t t;
      t.a = a;
      t.d = d;
      exp_q.push_back(t);
   endtask

   // Pops the oldest expected writeback and compares it with the outputs.
   task automatic check_wb(input string name);
      tests_run++;
      if (writeback_enable !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_en: got %b expected 1", name, writeback_enable);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL %s_queue: got empty expected queue, required one entry", name);
      end else begin
         e = exp_q.pop_front();
         if (writeback_address !== e.a || writeback_data !== e.d) begin
            tests_failed++;
            $display("FAIL %s_data: got %0d/%h expected %0d/%h", name,
                     writeback_address, writeback_data, e.a, e.d);
         end
      end
   endtask

   task automatic apply_reset();
      tick();
      reset = 1'b1;
      clear_reqs();
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      issue_valid = 1'b0;
`endif
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      bus.req_valid = 3'b111;
      @(negedge clock);
      tests_run++;
      if (bus.req_ready !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b expected 000", bus.req_ready);
      end
      tests_run++;
      if (writeback_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_wb_en: got %b expected 0", writeback_enable);
      end
      tests_run++;
      if (writeback_address !== '0) begin
         tests_failed++;
         $display("FAIL reset_wb_addr: got %0d expected 0", writeback_address);
      end
      tests_run++;
      if (writeback_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_wb_data: got %h expected 0", writeback_data);
      end
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      rs = 5'd9;
      tests_run++;
      if (rs_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_rs_busy: got %b expected 0", rs_busy);
      end
`endif
      tick();
      reset = 1'b0;
      clear_reqs();
   endtask

   task automatic test_single();
      tick();
      set_req(1, 5'd7, 32'hDEADBEEF);
      push_exp(5'd7, 32'hDEADBEEF);
      @(negedge clock);
      tests_run++;
      if (bus.req_ready !== 3'b010) begin
         tests_failed++;
         $display("FAIL single_ready: got %b expected 010", bus.req_ready);
      end
      tick();
      clear_reqs();
      @(negedge clock);
      check_wb("single_wb");
      tick();
      @(negedge clock);
      tests_run++;
      if (writeback_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_idle_en: got %b expected 0", writeback_enable);
      end
      tests_run++;
      if (writeback_address !== 5'd7 || writeback_data !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL single_hold: got %0d/%h expected 7/deadbeef",
                  writeback_address, writeback_data);
      end
   endtask

   // ptr is 2 here, so a grant to req 2 must move it to 0.
   task automatic test_addr_zero();
      tick();
      set_req(2, 5'd0, 32'h00001234);
      @(negedge clock);
      tests_run++;
      if (bus.req_ready !== 3'b100) begin
         tests_failed++;
         $display("FAIL zero_ready: got %b expected 100", bus.req_ready);
      end
      tick();
      clear_reqs();
      for (int i = 0; i < NR; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
      push_exp(5'd1, 32'hA000_0000);
      @(negedge clock);
      tests_run++;
      if (writeback_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_wb_en: got %b expected 0", writeback_enable);
      end
      tests_run++;
      if (bus.req_ready !== 3'b001) begin
         tests_failed++;
         $display("FAIL zero_ptr_advance: got %b expected 001", bus.req_ready);
      end
      tick();
      clear_reqs();
      @(negedge clock);
      check_wb("zero_follow_wb");
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] exp_ready;
      apply_reset();
      tick();
      for (int i = 0; i < NR; i++) set_req(i, 5'(i + 1), 32'hC0DE_0000 + 32'(i));
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         exp_ready = NR'(1) << (c % NR);
         tests_run++;
         if (bus.req_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL rr_grant_%0d: got %b expected %b", c, bus.req_ready, exp_ready);
         end
         tests_run++;
         if (!$onehot(bus.req_ready)) begin
            tests_failed++;
            $display("FAIL rr_onehot_%0d: got %b expected exactly one bit", c, bus.req_ready);
         end
         if (c > 0) check_wb("rr_wb");
         push_exp(5'((c % NR) + 1), 32'hC0DE_0000 + 32'(c % NR));
         tick();
      end
      clear_reqs();
      @(negedge clock);
      check_wb("rr_last_wb");
   endtask

   task automatic test_enable_low();
      tick();
      enable = 1'b0;
      set_req(0, 5'd4, 32'h00000055);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         tests_run++;
         if (bus.req_ready !== 3'b000) begin
            tests_failed++;
            $display("FAIL en_low_ready_%0d: got %b expected 000", c, bus.req_ready);
         end
         tests_run++;
         if (writeback_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_low_wb_en_%0d: got %b expected 0", c, writeback_enable);
         end
         tick();
      end
      enable = 1'b1;
      push_exp(5'd4, 32'h00000055);
      @(negedge clock);
      tests_run++;
      if (bus.req_ready !== 3'b001) begin
         tests_failed++;
         $display("FAIL en_rise_ready: got %b expected 001", bus.req_ready);
      end
      tick();
      clear_reqs();
      @(negedge clock);
      check_wb("en_rise_wb");
   endtask

`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
   task automatic test_scoreboard();
      tick();
      rs            = 5'd9;
      rt            = 5'd0;
      issue_valid   = 1'b1;
      issue_address = 5'd9;
      @(negedge clock);
      tests_run++;
      if (rs_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_issue_cycle: got %b expected 0", rs_busy);
      end
      tick();
      issue_valid = 1'b0;
      @(negedge clock);
      tests_run++;
      if (rs_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL sb_set: got %b expected 1", rs_busy);
      end
      tests_run++;
      if (rt_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_rt_zero: got %b expected 0", rt_busy);
      end
      tick();
      set_req(0, 5'd9, 32'h00000099);
      push_exp(5'd9, 32'h00000099);
      @(negedge clock);
      tests_run++;
      if (bus.req_ready !== 3'b001) begin
         tests_failed++;
         $display("FAIL sb_xfer_ready: got %b expected 001", bus.req_ready);
      end
      tests_run++;
      if (rs_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL sb_clear_same_cycle: got %b expected 1", rs_busy);
      end
      tick();
      clear_reqs();
      @(negedge clock);
      tests_run++;
      if (rs_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_cleared: got %b expected 0", rs_busy);
      end
      check_wb("sb_wb");
      // Re-issue so the bit is set, then issue and write back 9 together.
      tick();
      issue_valid = 1'b1;
      tick();
      set_req(1, 5'd9, 32'h00000077);
      push_exp(5'd9, 32'h00000077);
      @(negedge clock);
      tests_run++;
      if (bus.req_ready !== 3'b010) begin
         tests_failed++;
         $display("FAIL sb_both_ready: got %b expected 010", bus.req_ready);
      end
      tick();
      clear_reqs();
      issue_valid = 1'b0;
      @(negedge clock);
      tests_run++;
      if (rs_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL sb_set_wins: got %b expected 1", rs_busy);
      end
      check_wb("sb_both_wb");
   endtask
`endif

   task automatic test_reset_mid();
      tick();
      set_req(0, 5'd5, 32'h55555555);
      push_exp(5'd5, 32'h55555555);
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      issue_valid   = 1'b1;
      issue_address = 5'd5;
      rt            = 5'd5;
`endif
      @(negedge clock);
      tests_run++;
      if (bus.req_ready !== 3'b001) begin
         tests_failed++;
         $display("FAIL mid_ready: got %b expected 001", bus.req_ready);
      end
      tick();
      clear_reqs();
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      issue_valid = 1'b0;
`endif
      @(negedge clock);
      check_wb("mid_wb");
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      tests_run++;
      if (rt_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_rt_pending: got %b expected 1", rt_busy);
      end
`endif
      #1;
      set_req(2, 5'd3, 32'h33333333);
      reset = 1'b1;
      #1;
      tests_run++;
      if (writeback_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_drop_en: got %b expected 0", writeback_enable);
      end
      tests_run++;
      if (bus.req_ready !== 3'b000) begin
         tests_failed++;
         $display("FAIL mid_reset_ready: got %b expected 000", bus.req_ready);
      end
      tick();
      reset = 1'b0;
      clear_reqs();
      exp_q.delete();
      @(negedge clock);
      tests_run++;
      if (writeback_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_after_en: got %b expected 0", writeback_enable);
      end
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      tests_run++;
      if (rt_busy !== 1'b0 || rs_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_after_busy: got rt %b rs %b expected 0 0", rt_busy, rs_busy);
      end
`endif
      tick();
      set_req(0, 5'd5, 32'h55555555);
      set_req(2, 5'd3, 32'h33333333);
      push_exp(5'd5, 32'h55555555);
      @(negedge clock);
      tests_run++;
      if (bus.req_ready !== 3'b001) begin
         tests_failed++;
         $display("FAIL mid_represent_ready: got %b expected 001", bus.req_ready);
      end
      tick();
      clear_reqs();
      @(negedge clock);
      check_wb("mid_represent_wb");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset  = 1'b0;
      enable = 1'b1;
      clear_reqs();
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      issue_valid   = 1'b0;
      issue_address = '0;
      rs            = '0;
      rt            = '0;
`endif
      #2;
      reset = 1'b1;
      test_reset();
      test_single();
      test_addr_zero();
      test_round_robin();
      test_enable_low();
`ifdef WRITEBACK_ARBITER_SCOREBOARD_EN
      test_scoreboard();
`endif
      test_reset_mid();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL queue_drained: got %0d entries expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
